// File: rtl/rvh_l1d_pkg.sv
// Shared types and defaults for the L1D snoop scheduler: request/response
// field layouts, FSM state encoding and the default sizing parameters.
package rvh_l1d_pkg;

    // Default sizing for the snoop scheduler.
    localparam int unsigned SnqDepthDefault  = 4;
    localparam int unsigned StarveMaxDefault = 4;
    localparam int unsigned WdogMaxDefault   = 64;

    // Snoop request layout: [17:4] line address, [3:0] snoop type.
    localparam int unsigned SnAddrW = 14;
    localparam int unsigned SnTypeW = 4;
    localparam int unsigned SnReqW  = SnAddrW + SnTypeW;

    // Engine response beat layout: [65] has-data, [64:1] data, [0] done.
    localparam int unsigned SnDataW          = 64;
    localparam int unsigned SnRespW          = SnDataW + 2;
    localparam int unsigned SnRespDoneBit    = 0;
    localparam int unsigned SnRespHasDataBit = SnRespW - 1;

    // A data snoop returns one full line as eight beats.
    localparam int unsigned SnBeatCntW = 3;

    typedef struct packed {
        logic [SnAddrW-1:0] addr;
        logic [SnTypeW-1:0] typ;
    } sn_req_t;

    typedef struct packed {
        logic               has_data;
        logic [SnDataW-1:0] data;
        logic               done;
    } sn_resp_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitResp = 2'd1,
        StData     = 2'd2
    } sn_state_e;

endpackage

// File: rtl/l1d_snoop_fifo.sv
// Snoop request queue: plain circular FIFO with a wrap bit on each pointer so
// full and empty are distinguishable. Push and pop together are legal at any
// fill level, including full (the freed slot is the one being written).
module l1d_snoop_fifo
    import rvh_l1d_pkg::*;
#(
    parameter int unsigned DEPTH = SnqDepthDefault,
    parameter int unsigned WIDTH = SnReqW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rptr_q[AW-1:0]];

    // Pointer update; wrap bit toggles each lap of the storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointed at by a valid entry.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/l1d_snoop_sched.sv
// L1D snoop scheduler: queues incoming NoC snoops, arbitrates the shared
// tag/LST read port against the core pipeline with starvation protection,
// tracks one in-flight snoop through its response beats and forwards those
// beats to the NoC through a one-entry response register.
module l1d_snoop_sched
    import rvh_l1d_pkg::*;
#(
    parameter int unsigned SNQ_DEPTH  = SnqDepthDefault,
    parameter int unsigned STARVE_MAX = StarveMaxDefault,
    parameter int unsigned WDOG_MAX   = WdogMaxDefault
) (
    input  logic               clk,
    input  logic               rstn,
    // Incoming snoops from the NoC
    input  logic               noc_sn_req_valid_i,
    output logic               noc_sn_req_ready_o,
    input  logic [SnReqW-1:0]  noc_sn_req_i,
    // Shared tag/LST port arbitration with the core pipeline
    input  logic               pipe_lkup_req_i,
    output logic               pipe_stall_o,
    // Issue to the snoop engine
    output logic               sn_req_hsk_o,
    output logic [SnReqW-1:0]  sn_req_o,
    input  logic               sn_empty_i,
    // Engine response beats
    input  logic               sn_resp_valid_i,
    input  logic [SnRespW-1:0] sn_resp_i,
    // Response to the NoC
    output logic               noc_sn_resp_valid_o,
    input  logic               noc_sn_resp_ready_i,
    output logic [SnRespW-1:0] noc_sn_resp_o,
    // Status
    output logic               sn_busy_o,
    output logic               wdog_err_o
);

    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam int unsigned WdogW   = $clog2(WDOG_MAX + 1);

    localparam logic [StarveW-1:0]    StarveLimit = StarveW'(STARVE_MAX);
    localparam logic [WdogW-1:0]      WdogLast    = WdogW'(WDOG_MAX - 1);
    localparam logic [SnBeatCntW-1:0] LastBeat    = '1;

    // Queue interface
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SnReqW-1:0] fifo_head;

    // State
    sn_state_e              state_q;
    logic [SnBeatCntW-1:0]  beat_cnt_q;
    logic [WdogW-1:0]       wdog_cnt_q;
    logic                   wdog_err_q;
    logic [StarveW-1:0]     starve_cnt_q;
    logic                   resp_vld_q;
    logic [SnRespW-1:0]     resp_q;

    // Decoded control
    logic busy;
    logic eligible;
    logic issue;
    logic beat;
    logic beat_done;
    logic beat_has_data;
    logic stray_beat;
    logic resp_load;
    logic resp_drop;
    logic wdog_hit;

    l1d_snoop_fifo #(
        .DEPTH (SNQ_DEPTH),
        .WIDTH (SnReqW)
    ) u_snoop_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (noc_sn_req_i),
        .pop       (issue),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign noc_sn_req_ready_o = ~fifo_full;
    assign fifo_push          = noc_sn_req_valid_i & ~fifo_full;

    // Busy comes straight from the registered state, so the cycle after an
    // issue is already blocked even though sn_empty_i has not fallen yet.
    assign busy     = (state_q != StIdle);
    assign eligible = ~fifo_empty & ~busy & sn_empty_i & ~resp_vld_q;
    assign issue    = eligible & (~pipe_lkup_req_i | (starve_cnt_q == StarveLimit));

    assign sn_req_hsk_o = issue;
    assign sn_req_o     = fifo_empty ? '0 : fifo_head;
    assign pipe_stall_o = pipe_lkup_req_i & issue;

    assign beat_done     = sn_resp_i[SnRespDoneBit];
    assign beat_has_data = sn_resp_i[SnRespHasDataBit];
    assign beat          = sn_resp_valid_i & busy;
    assign stray_beat    = sn_resp_valid_i & ~busy;
    // The engine cannot be back-pressured: a beat that finds the register full
    // and not draining is lost and flagged.
    assign resp_load     = beat & (~resp_vld_q | noc_sn_resp_ready_i);
    assign resp_drop     = beat & resp_vld_q & ~noc_sn_resp_ready_i;
    assign wdog_hit      = busy & (wdog_cnt_q == WdogLast);

    assign sn_busy_o           = busy;
    assign wdog_err_o          = wdog_err_q;
    assign noc_sn_resp_valid_o = resp_vld_q;
    assign noc_sn_resp_o       = resp_q;

    // Starvation counter: counts eligible cycles lost to the pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_q <= '0;
        end else if (issue) begin
            starve_cnt_q <= '0;
        end else if (eligible && (starve_cnt_q != StarveLimit)) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end

    // One-entry response register towards the NoC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_vld_q <= 1'b0;
            resp_q     <= '0;
        end else if (resp_load) begin
            resp_vld_q <= 1'b1;
            resp_q     <= sn_resp_i;
        end else if (noc_sn_resp_ready_i) begin
            resp_vld_q <= 1'b0;
        end
    end

    // In-flight snoop FSM with beat counter, watchdog and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (resp_drop || stray_beat || wdog_hit) wdog_err_q <= 1'b1;

            // Watchdog runs while busy; transitions to idle below override it.
            wdog_cnt_q <= busy ? wdog_cnt_q + 1'b1 : '0;

            if (wdog_hit) begin
                state_q    <= StIdle;
                beat_cnt_q <= '0;
                wdog_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (issue) state_q <= StWaitResp;
                    end
                    StWaitResp: begin
                        if (beat) begin
                            if (beat_done) begin
                                state_q    <= StIdle;
                                wdog_cnt_q <= '0;
                            end else if (beat_has_data) begin
                                state_q    <= StData;
                                beat_cnt_q <= 3'd1;
                            end
                        end
                    end
                    StData: begin
                        if (beat) begin
                            if (beat_cnt_q == LastBeat) begin
                                state_q    <= StIdle;
                                beat_cnt_q <= '0;
                                wdog_cnt_q <= '0;
                            end else begin
                                beat_cnt_q <= beat_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q    <= StIdle;
                        beat_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_l1d_snoop_sched.sv
// Directed bench for l1d_snoop_sched. Inputs change 1ns after the rising
// edge; outputs are compared 2ns after it.
module tb_l1d_snoop_sched;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        noc_sn_req_valid_i;
    logic        noc_sn_req_ready_o;
    logic [17:0] noc_sn_req_i;
    logic        pipe_lkup_req_i;
    logic        pipe_stall_o;
    logic        sn_req_hsk_o;
    logic [17:0] sn_req_o;
    logic        sn_empty_i;
    logic        sn_resp_valid_i;
    logic [65:0] sn_resp_i;
    logic        noc_sn_resp_valid_o;
    logic        noc_sn_resp_ready_i;
    logic [65:0] noc_sn_resp_o;
    logic        sn_busy_o;
    logic        wdog_err_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [17:0] pq [5];

    always #5 clk = ~clk;

    l1d_snoop_sched #(
        .SNQ_DEPTH  (4),
        .STARVE_MAX (4),
        .WDOG_MAX   (64)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .noc_sn_req_valid_i  (noc_sn_req_valid_i),
        .noc_sn_req_ready_o  (noc_sn_req_ready_o),
        .noc_sn_req_i        (noc_sn_req_i),
        .pipe_lkup_req_i     (pipe_lkup_req_i),
        .pipe_stall_o        (pipe_stall_o),
        .sn_req_hsk_o        (sn_req_hsk_o),
        .sn_req_o            (sn_req_o),
        .sn_empty_i          (sn_empty_i),
        .sn_resp_valid_i     (sn_resp_valid_i),
        .sn_resp_i           (sn_resp_i),
        .noc_sn_resp_valid_o (noc_sn_resp_valid_o),
        .noc_sn_resp_ready_i (noc_sn_resp_ready_i),
        .noc_sn_resp_o       (noc_sn_resp_o),
        .sn_busy_o           (sn_busy_o),
        .wdog_err_o          (wdog_err_o)
    );

    task automatic chk(input string tag, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next issue, check it, then finish it with a done beat.
    task automatic serve(input logic [17:0] exp, input string tag);
        int n = 0;
        #1;
        while (sn_req_hsk_o !== 1'b1 && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk({tag, "_hsk"}, sn_req_hsk_o, 1'b1);
        chk({tag, "_req"}, sn_req_o, exp);
        tick();
        sn_resp_valid_i = 1'b1;
        sn_resp_i       = 66'h1;
        tick();
        sn_resp_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        noc_sn_req_valid_i  = 1'b0;
        noc_sn_req_i        = '0;
        pipe_lkup_req_i     = 1'b0;
        sn_empty_i          = 1'b1;
        sn_resp_valid_i     = 1'b0;
        sn_resp_i           = '0;
        noc_sn_resp_ready_i = 1'b1;
        pq[0] = 18'h0_1001; pq[1] = 18'h0_2002; pq[2] = 18'h0_3003;
        pq[3] = 18'h0_4004; pq[4] = 18'h0_5005;

        // Reset values
        #1 rstn = 1'b0;
        #2;
        chk("rst_hsk", sn_req_hsk_o, 1'b0);
        chk("rst_nocv", noc_sn_resp_valid_o, 1'b0);
        chk("rst_err", wdog_err_o, 1'b0);
        chk("rst_busy", sn_busy_o, 1'b0);
        chk("rst_stall", pipe_stall_o, 1'b0);
        chk("rst_ready", noc_sn_req_ready_o, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single snoop, done-only response
        noc_sn_req_valid_i = 1'b1;
        noc_sn_req_i       = 18'h2A5F1;
        #1;
        chk("t1_hsk_pre", sn_req_hsk_o, 1'b0);
        chk("t1_reqo_empty", sn_req_o, 18'h0);
        tick();
        noc_sn_req_valid_i = 1'b0;
        #1;
        chk("t1_hsk", sn_req_hsk_o, 1'b1);
        chk("t1_req", sn_req_o, 18'h2A5F1);
        chk("t1_stall", pipe_stall_o, 1'b0);
        tick();
        #1;
        chk("t1_busy", sn_busy_o, 1'b1);
        chk("t1_hsk_off", sn_req_hsk_o, 1'b0);
        sn_resp_valid_i = 1'b1;
        sn_resp_i       = 66'h1;
        tick();
        sn_resp_valid_i = 1'b0;
        #1;
        chk("t1_busy_clr", sn_busy_o, 1'b0);
        chk("t1_nocv", noc_sn_resp_valid_o, 1'b1);
        chk("t1_nocd", noc_sn_resp_o, 66'h1);
        tick();
        #1;
        chk("t1_nocv_clr", noc_sn_resp_valid_o, 1'b0);

        // Starvation: pipeline wins four eligible cycles, snoop wins the fifth
        pipe_lkup_req_i    = 1'b1;
        noc_sn_req_valid_i = 1'b1;
        noc_sn_req_i       = 18'h00123;
        tick();
        noc_sn_req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_stall_lo", pipe_stall_o, 1'b0);
            chk("t2_hsk_lo", sn_req_hsk_o, 1'b0);
            tick();
        end
        #1;
        chk("t2_hsk5", sn_req_hsk_o, 1'b1);
        chk("t2_stall5", pipe_stall_o, 1'b1);
        chk("t2_req", sn_req_o, 18'h00123);
        tick();
        pipe_lkup_req_i = 1'b0;
        sn_resp_valid_i = 1'b1;
        sn_resp_i       = 66'h1;
        tick();
        sn_resp_valid_i = 1'b0;
        tick();

        // Eight-beat data snoop, then the queued request issues
        noc_sn_req_valid_i = 1'b1;
        noc_sn_req_i       = 18'h3C0DE;
        tick();
        noc_sn_req_i = 18'h01234;
        #1;
        chk("t3_hsk_a", sn_req_hsk_o, 1'b1);
        chk("t3_req_a", sn_req_o, 18'h3C0DE);
        tick();
        noc_sn_req_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sn_resp_valid_i = 1'b1;
            sn_resp_i       = {1'b1, 64'(i), 1'b0};
            #1;
            chk("t3_busy", sn_busy_o, 1'b1);
            chk("t3_hsk_blk", sn_req_hsk_o, 1'b0);
            if (i > 0) begin
                chk("t3_nocv", noc_sn_resp_valid_o, 1'b1);
                chk("t3_beat", noc_sn_resp_o, {1'b1, 64'(i - 1), 1'b0});
            end
            tick();
        end
        sn_resp_valid_i = 1'b0;
        #1;
        chk("t3_nocv7", noc_sn_resp_valid_o, 1'b1);
        chk("t3_beat7", noc_sn_resp_o, {1'b1, 64'd7, 1'b0});
        chk("t3_idle", sn_busy_o, 1'b0);
        chk("t3_hsk_held", sn_req_hsk_o, 1'b0);
        tick();
        #1;
        chk("t3_hsk_b", sn_req_hsk_o, 1'b1);
        chk("t3_req_b", sn_req_o, 18'h01234);
        tick();
        sn_resp_valid_i = 1'b1;
        sn_resp_i       = 66'h1;
        tick();
        sn_resp_valid_i = 1'b0;
        tick();

        // Fill the queue while the engine is busy; order preserved
        sn_empty_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            noc_sn_req_valid_i = 1'b1;
            noc_sn_req_i       = pq[k];
            #1;
            chk("t4_ready", noc_sn_req_ready_o, (k < 4));
            chk("t4_hsk_blk", sn_req_hsk_o, 1'b0);
            tick();
        end
        sn_empty_i = 1'b1;
        #1;
        chk("t4_hsk0", sn_req_hsk_o, 1'b1);
        chk("t4_req0", sn_req_o, pq[0]);
        chk("t4_full", noc_sn_req_ready_o, 1'b0);
        tick();
        #1;
        chk("t4_ready_back", noc_sn_req_ready_o, 1'b1);
        tick();
        noc_sn_req_valid_i = 1'b0;
        sn_resp_valid_i    = 1'b1;
        sn_resp_i          = 66'h1;
        tick();
        sn_resp_valid_i = 1'b0;
        tick();
        for (int k = 1; k < 5; k++) serve(pq[k], "t4_order");

        // Watchdog: no response for WDOG_MAX cycles
        noc_sn_req_valid_i = 1'b1;
        noc_sn_req_i       = 18'h15555;
        tick();
        noc_sn_req_valid_i = 1'b0;
        #1;
        chk("t5_hsk", sn_req_hsk_o, 1'b1);
        tick();
        for (int i = 0; i < 63; i++) tick();
        #1;
        chk("t5_busy63", sn_busy_o, 1'b1);
        chk("t5_err63", wdog_err_o, 1'b0);
        tick();
        #1;
        chk("t5_idle64", sn_busy_o, 1'b0);
        chk("t5_err64", wdog_err_o, 1'b1);
        chk("t5_nocv", noc_sn_resp_valid_o, 1'b0);
        tick();
        noc_sn_req_valid_i = 1'b1;
        noc_sn_req_i       = 18'h0AAAA;
        tick();
        noc_sn_req_valid_i = 1'b0;
        serve(18'h0AAAA, "t5_next");
        #1;
        chk("t5_err_sticky", wdog_err_o, 1'b1);

        // Reset in the middle of a data snoop with another request queued
        tick();
        noc_sn_req_valid_i = 1'b1;
        noc_sn_req_i       = 18'h2BEEF;
        tick();
        noc_sn_req_i = 18'h11111;
        #1;
        chk("t6_hsk", sn_req_hsk_o, 1'b1);
        tick();
        noc_sn_req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sn_resp_valid_i = 1'b1;
            sn_resp_i       = {1'b1, 64'(i + 16), 1'b0};
            tick();
        end
        sn_resp_i = {1'b1, 64'd19, 1'b0};
        #1;
        chk("t6_pre_nocv", noc_sn_resp_valid_o, 1'b1);
        chk("t6_pre_busy", sn_busy_o, 1'b1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_hsk", sn_req_hsk_o, 1'b0);
        chk("t6_rst_nocv", noc_sn_resp_valid_o, 1'b0);
        chk("t6_rst_err", wdog_err_o, 1'b0);
        chk("t6_rst_busy", sn_busy_o, 1'b0);
        chk("t6_rst_stall", pipe_stall_o, 1'b0);
        chk("t6_rst_ready", noc_sn_req_ready_o, 1'b1);
        chk("t6_rst_reqo", sn_req_o, 18'h0);
        @(negedge clk);
        sn_resp_valid_i = 1'b0;
        rstn            = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            chk("t6_post_nocv", noc_sn_resp_valid_o, 1'b0);
            chk("t6_post_hsk", sn_req_hsk_o, 1'b0);
        end

        // Response beat with nothing in flight is ignored and flagged
        sn_resp_valid_i = 1'b1;
        sn_resp_i       = 66'h1;
        tick();
        sn_resp_valid_i = 1'b0;
        #1;
        chk("t7_err", wdog_err_o, 1'b1);
        chk("t7_nocv", noc_sn_resp_valid_o, 1'b0);
        chk("t7_busy", sn_busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
